// File: rtl/irq_flag_reg.sv
// Interrupt flag register (IF, 0xFF0F): latches peripheral requests, cleared by core ack or CPU write.
// Latency: one CLK edge from request/ack/write to flag; read path is combinational.
// Backpressure: none; requests are strobes and a set always wins, so no request is lost.
// Optional IRQ_EDGE_DETECT_EN: edge-triggered request capture (default build is level-triggered).
module irq_flag_reg (
    input  logic        CLK,
    input  logic        RES,
    input  logic [15:0] A,
    input  logic        RD,
    input  logic        WR,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [4:0]  INT_REQ,
    input  logic [7:0]  CPU_IRQ_ACK,
    output logic [7:0]  CPU_IRQ_TRIG,
    output logic        IRQ_PEND
);

    logic [4:0] if_q;
    logic [4:0] if_d;
    logic [4:0] ack_q;
    logic [4:0] set_vec;
    logic [4:0] clr_vec;
    logic       sel;
    logic       wr_sel;

    // Upper data/ack bits carry no state in this register.
    logic       unused_hi;
    assign unused_hi = &{1'b0, D_IN[7:5], CPU_IRQ_ACK[7:5]};

    assign sel    = (A == 16'hFF0F);
    assign wr_sel = WR & sel;

`ifdef IRQ_EDGE_DETECT_EN
    logic [4:0] req_q;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            req_q <= 5'h00;
        end else begin
            req_q <= INT_REQ;
        end
    end

    assign set_vec = INT_REQ & ~req_q;
`else
    assign set_vec = INT_REQ;
`endif

    // A held ack clears only once, so a flag re-raised during the ack survives.
    assign clr_vec = CPU_IRQ_ACK[4:0] & ~ack_q;

    // Per bit: set beats write, write beats ack-clear.
    always_comb begin
        if_d = if_q;
        for (int i = 0; i < 5; i++) begin
            if (set_vec[i]) begin
                if_d[i] = 1'b1;
            end else if (wr_sel) begin
                if_d[i] = D_IN[i];
            end else if (clr_vec[i]) begin
                if_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            if_q  <= 5'h00;
            ack_q <= 5'h00;
        end else begin
            if_q  <= if_d;
            ack_q <= CPU_IRQ_ACK[4:0];
        end
    end

    assign D_OUT        = {3'b111, if_q};
    assign D_OE         = RD & sel;
    assign CPU_IRQ_TRIG = {3'b000, if_q};
    assign IRQ_PEND     = |if_q;

endmodule

// File: tb/tb_irq_flag_reg.sv
// Directed vector bench for irq_flag_reg; expectations cover both request-capture builds.
module tb_irq_flag_reg;

    logic        CLK;
    logic        RES;
    logic [15:0] A;
    logic        RD;
    logic        WR;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic [4:0]  INT_REQ;
    logic [7:0]  CPU_IRQ_ACK;
    logic [7:0]  CPU_IRQ_TRIG;
    logic        IRQ_PEND;

    int errors = 0;
    int checks = 0;

    irq_flag_reg dut (
        .CLK          (CLK),
        .RES          (RES),
        .A            (A),
        .RD           (RD),
        .WR           (WR),
        .D_IN         (D_IN),
        .D_OUT        (D_OUT),
        .D_OE         (D_OE),
        .INT_REQ      (INT_REQ),
        .CPU_IRQ_ACK  (CPU_IRQ_ACK),
        .CPU_IRQ_TRIG (CPU_IRQ_TRIG),
        .IRQ_PEND     (IRQ_PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [4:0]  req;
        logic [7:0]  ack;
        logic [15:0] addr;
        logic        wr;
        logic        rd;
        logic [7:0]  din;
        logic [7:0]  exp_trig;
        logic [7:0]  exp_dout;
        logic        exp_oe;
    } vec_t;

    vec_t vecs[17];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] trig,
                             input logic [7:0] dout, input logic oe);
        check8({name, ".trig"}, CPU_IRQ_TRIG, trig);
        check8({name, ".pend"}, {7'b0, IRQ_PEND}, {7'b0, (trig[4:0] != 5'h00)});
        check8({name, ".dout"}, D_OUT, dout);
        check8({name, ".oe"}, {7'b0, D_OE}, {7'b0, oe});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [4:0] req, input logic [7:0] ack, input logic [15:0] addr,
                         input logic wr, input logic rd, input logic [7:0] din);
        INT_REQ     = req;
        CPU_IRQ_ACK = ack;
        A           = addr;
        WR          = wr;
        RD          = rd;
        D_IN        = din;
    endtask

    initial begin
        //                name        req    ack    addr      wr rd din    trig   dout   oe
        vecs[0]  = '{"wr00",      5'h00, 8'h00, 16'hFF0F, 1, 0, 8'h00, 8'h00, 8'hE0, 0};
        vecs[1]  = '{"req2",      5'h04, 8'h00, 16'hFF0F, 0, 1, 8'h00, 8'h04, 8'hE4, 1};
        vecs[2]  = '{"ack2_a",    5'h00, 8'h04, 16'hFF0F, 0, 1, 8'h00, 8'h00, 8'hE0, 1};
        vecs[3]  = '{"ack2_b",    5'h00, 8'h04, 16'hFF0F, 0, 1, 8'h00, 8'h00, 8'hE0, 1};
        vecs[4]  = '{"reset_hld", 5'h04, 8'h04, 16'hFF0F, 0, 1, 8'h00, 8'h04, 8'hE4, 1};
        vecs[5]  = '{"ack_hld",   5'h00, 8'h04, 16'hFF0F, 0, 1, 8'h00, 8'h04, 8'hE4, 1};
        vecs[6]  = '{"wrFF",      5'h00, 8'h00, 16'hFF0F, 1, 1, 8'hFF, 8'h1F, 8'hFF, 1};
        vecs[7]  = '{"rdFF",      5'h00, 8'h00, 16'hFF0F, 0, 1, 8'h00, 8'h1F, 8'hFF, 1};
        vecs[8]  = '{"wr00b",     5'h00, 8'h00, 16'hFF0F, 1, 1, 8'h00, 8'h00, 8'hE0, 1};
        vecs[9]  = '{"wrFF0E",    5'h00, 8'h00, 16'hFF0E, 1, 1, 8'hFF, 8'h00, 8'hE0, 0};
        vecs[10] = '{"coll_r_w0", 5'h01, 8'h01, 16'hFF0F, 1, 0, 8'h00, 8'h01, 8'hE1, 0};
        vecs[11] = '{"coll_w1_a", 5'h00, 8'h02, 16'hFF0F, 1, 0, 8'h02, 8'h02, 8'hE2, 0};
        vecs[12] = '{"idle",      5'h00, 8'h00, 16'h0000, 0, 1, 8'h00, 8'h02, 8'hE2, 0};
        vecs[13] = '{"coll_w0_a", 5'h00, 8'h02, 16'hFF0F, 1, 0, 8'h00, 8'h00, 8'hE0, 0};
        vecs[14] = '{"multi_set", 5'h0A, 8'hE0, 16'h0000, 0, 0, 8'h00, 8'h0A, 8'hEA, 0};
        vecs[15] = '{"ack3",      5'h00, 8'h08, 16'h0000, 0, 0, 8'h00, 8'h02, 8'hE2, 0};
        vecs[16] = '{"ack1",      5'h00, 8'h02, 16'h0000, 0, 0, 8'h00, 8'h00, 8'hE0, 0};

        // Reset held with all sources high.
        RES = 1'b1;
        drive(5'h1F, 8'h00, 16'hFF0F, 0, 1, 8'h00);
        #1;
        check_all("rst", 8'h00, 8'hE0, 1'b1);
        tick();
        tick();
        check_all("rst_hold", 8'h00, 8'hE0, 1'b1);
        RES = 1'b0;
        tick();
        check_all("rst_rel", 8'h1F, 8'hFF, 1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].ack, vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].din);
            tick();
            check_all(vecs[i].name, vecs[i].exp_trig, vecs[i].exp_dout, vecs[i].exp_oe);
        end

        // Request held across an ack: edge build clears once, level build keeps re-setting.
        drive(5'h10, 8'h00, 16'h0000, 0, 0, 8'h00);
        tick();
        check8("hold_set", CPU_IRQ_TRIG, 8'h10);
        drive(5'h10, 8'h10, 16'h0000, 0, 0, 8'h00);
        tick();
`ifdef IRQ_EDGE_DETECT_EN
        check8("hold_ack", CPU_IRQ_TRIG, 8'h00);
`else
        check8("hold_ack", CPU_IRQ_TRIG, 8'h10);
`endif
        drive(5'h10, 8'h00, 16'h0000, 0, 0, 8'h00);
        tick();
`ifdef IRQ_EDGE_DETECT_EN
        check8("hold_after", CPU_IRQ_TRIG, 8'h00);
`else
        check8("hold_after", CPU_IRQ_TRIG, 8'h10);
`endif

        // Asynchronous reset between edges.
        drive(5'h00, 8'h00, 16'hFF0F, 1, 0, 8'h15);
        tick();
        check8("pre_arst", CPU_IRQ_TRIG, 8'h15);
        drive(5'h00, 8'h00, 16'h0000, 0, 0, 8'h00);
        #2;
        RES = 1'b1;
        #1;
        check_all("arst", 8'h00, 8'hE0, 1'b0);
        tick();
        RES = 1'b0;
        tick();
        check8("post_arst", CPU_IRQ_TRIG, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
